// File: rtl/spi_master_par.sv
// rtl/spi_master_par.sv - parametrised full-duplex SPI master with start/busy/done handshake
//
// Parameters: DATA_W bits per word (>=2), CLK_DIV clk cycles per SCLK half-period (>=1),
//             NUM_CS chip-select lines (>=2).
// Ports:
//   clk, rst_n         system clock (rising edge), asynchronous active-low reset
//   start              transfer request, only looked at while idle
//   cpol, cpha         SPI mode, latched at start
//   cs_sel             target chip select, latched at start (out-of-range selects none)
//   tx_data            word to send MSB first, latched at start
//   rx_data            last received word, updated together with done
//   busy, done         transfer in progress / one-cycle end-of-transfer pulse
//   sclk, mosi, miso   SPI serial clock and data
//   cs_n               active-low chip selects, at most one low
// Optional build macro: SPI_LOOPBACK_EN - receive shifter takes the internal mosi instead of miso.
module spi_master_par #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2,
  parameter int NUM_CS  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      cpol,
  input  logic                      cpha,
  input  logic [$clog2(NUM_CS)-1:0] cs_sel,
  input  logic [DATA_W-1:0]         tx_data,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      busy,
  output logic                      done,
  output logic                      sclk,
  output logic                      mosi,
  input  logic                      miso,
  output logic [NUM_CS-1:0]         cs_n
);

  localparam int CS_W  = $clog2(NUM_CS);
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDG_W = $clog2(2 * DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [EDG_W-1:0] EDG_LAST  = EDG_W'(2 * DATA_W);
  localparam logic [EDG_W-1:0] EDG_FINAL_TRAIL_PREV = EDG_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt;
  logic [EDG_W-1:0]   edge_cnt;   // SCLK edges already produced in this transfer
  logic               cpha_q;
  logic [DATA_W-1:0]  tx_sr;
  logic [DATA_W-1:0]  rx_sr;
  logic               half_end;
  logic               sclk_edge;
  logic               hold_exit;
  logic               lead;
  logic               sample;
  logic               mosi_shift;
  logic               rx_bit;

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso;
  assign rx_bit      = mosi;
`else
  assign rx_bit      = miso;
`endif

  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] m;
    m = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (sel == CS_W'(i)) m[i] = 1'b0;
    end
    return m;
  endfunction

  assign busy     = (state_q != IDLE);
  assign half_end = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Each SETUP/XFER/HOLD phase ends on the last cycle of a CLK_DIV half-period.
  // Toggling on the SETUP end and on every XFER end except the final one yields
  // exactly 2*DATA_W edges, leaving sclk back at its idle level for HOLD.
  always_comb begin
    state_d   = state_q;
    sclk_edge = 1'b0;
    hold_exit = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = SETUP;
      SETUP: if (half_end) begin
               state_d   = XFER;
               sclk_edge = 1'b1;
             end
      XFER:  if (half_end) begin
               if (edge_cnt == EDG_LAST) state_d = HOLD;
               else                      sclk_edge = 1'b1;
             end
      HOLD:  if (half_end) begin
               state_d   = IDLE;
               hold_exit = 1'b1;
             end
      default: state_d = IDLE;
    endcase
  end

  // The edge about to be produced is odd (leading) when the count so far is even.
  assign lead       = ~edge_cnt[0];
  assign sample     = sclk_edge & (lead ^ cpha_q);
  // cpha=0 pre-loads the MSB at start, so the final trailing edge must not shift.
  assign mosi_shift = sclk_edge & (cpha_q ? lead : (~lead & (edge_cnt != EDG_FINAL_TRAIL_PREV)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      edge_cnt <= '0;
      cpha_q   <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx_data  <= '0;
      cs_n     <= '1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= hold_exit;
      if (state_q == IDLE) begin
        cnt  <= '0;
        sclk <= cpol;    // idle level follows cpol one cycle late; also the latched level at start
        if (start) begin
          cpha_q   <= cpha;
          tx_sr    <= tx_data;
          rx_sr    <= '0;
          edge_cnt <= '0;
          cs_n     <= cs_decode(cs_sel);
          mosi     <= cpha ? 1'b0 : tx_data[DATA_W-1];
        end
      end else begin
        cnt <= half_end ? '0 : cnt + 1'b1;
        if (sclk_edge) begin
          sclk     <= ~sclk;
          edge_cnt <= edge_cnt + 1'b1;
        end
        if (sample) rx_sr <= {rx_sr[DATA_W-2:0], rx_bit};
        if (mosi_shift) begin
          mosi  <= cpha_q ? tx_sr[DATA_W-1] : tx_sr[DATA_W-2];
          tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
        end
        if (hold_exit) begin
          cs_n    <= '1;
          rx_data <= rx_sr;
        end
      end
    end
  end

endmodule
